// File: rtl/mac_grid_acc.sv
// mac_grid_acc: ROWS x COLS signed MAC grid with per-column weight banks,
// two-stage pipeline, saturating/wrapping accumulate and drained readout.
module mac_grid_acc #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int DW = 8,
  parameter int WDEPTH = 32,
  parameter int ACCW = 24,
  parameter bit SAT = 1'b1,
  localparam int AW = WDEPTH > 1 ? $clog2(WDEPTH) : 1,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 WE,
  input  logic [CW-1:0]        wCol,
  input  logic [AW-1:0]        wAddr,
  input  logic [DW-1:0]        wData,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*DW-1:0]   data_in,
  input  logic [ROWS-1:0]      rowEn,
  input  logic [AW-1:0]        cAddr,
  input  logic                 clr,
  input  logic                 rd_req,
  input  logic [RW-1:0]        rd_row,
  output logic                 rd_valid,
  output logic [COLS*ACCW-1:0] dataOut,
  output logic [COLS-1:0]      ovf
);

  localparam int PW = 2 * DW;
  localparam int SW = ACCW + 1;
  localparam logic [ACCW-1:0] MAXV = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] MINV = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_t;

  state_t state, state_nx;

  logic signed [DW-1:0]   wmem [COLS][WDEPTH];
  logic signed [DW-1:0]   s1_d [ROWS];
  logic signed [DW-1:0]   s1_w [COLS];
  logic signed [PW-1:0]   s2_p [ROWS][COLS];
  logic signed [ACCW-1:0] acc [ROWS][COLS];
  logic signed [ACCW-1:0] acc_nx [ROWS][COLS];
  logic signed [SW-1:0]   sum;
  logic [ROWS-1:0]        s1_en, s2_en;
  logic [COLS-1:0]        ovf_hit;
  logic [RW-1:0]          rd_q;
  logic                   s1_v, s2_v;
  logic                   accept, empty;

  assign accept = in_valid && in_ready;
  assign empty  = !s1_v && !s2_v;

  // Non-blocking write keeps a same-edge stage-1 read on the old weight.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++)
        for (int a = 0; a < WDEPTH; a++)
          wmem[c][a] <= '0;
    end else if (WE) begin
      wmem[wCol][wAddr] <= wData;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s1_v  <= 1'b0;
      s2_v  <= 1'b0;
      s1_en <= '0;
      s2_en <= '0;
      for (int r = 0; r < ROWS; r++) s1_d[r] <= '0;
      for (int c = 0; c < COLS; c++) s1_w[c] <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          s2_p[r][c] <= '0;
    end else begin
      s1_v  <= accept;
      s2_v  <= s1_v;
      s2_en <= s1_en;
      if (accept) begin
        s1_en <= rowEn;
        for (int r = 0; r < ROWS; r++)
          s1_d[r] <= data_in[r*DW +: DW];
        for (int c = 0; c < COLS; c++)
          s1_w[c] <= wmem[c][cAddr];
      end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          s2_p[r][c] <= PW'(s1_d[r]) * PW'(s1_w[c]);
    end
  end

  // clr zeroes the base first, so a landing product adds to 0.
  always_comb begin
    ovf_hit = '0;
    sum     = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        acc_nx[r][c] = clr ? '0 : acc[r][c];
        if (s2_v && s2_en[r]) begin
          sum = SW'(acc_nx[r][c]) + SW'(s2_p[r][c]);
          if (sum[ACCW] != sum[ACCW-1]) begin
            ovf_hit[c] = 1'b1;
            if (SAT)
              acc_nx[r][c] = sum[ACCW] ? MINV : MAXV;
            else
              acc_nx[r][c] = sum[ACCW-1:0];
          end else begin
            acc_nx[r][c] = sum[ACCW-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ovf <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          acc[r][c] <= '0;
    end else begin
      ovf <= (clr ? '0 : ovf) | ovf_hit;
      acc <= acc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    rd_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !rd_req;
        if (rd_req) state_nx = DRAIN;
      end
      DRAIN: if (empty) state_nx = RESP;
      RESP: begin
        rd_valid = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_q    <= '0;
      dataOut <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && rd_req) rd_q <= rd_row;
      if (state == DRAIN && empty)
        for (int c = 0; c < COLS; c++)
          dataOut[c*ACCW +: ACCW] <= acc[rd_q][c];
    end
  end

endmodule

// File: tb/tb_mac_grid_acc.sv
// Bench for mac_grid_acc: saturating and wrapping builds side by side,
// checked against a plain-arithmetic grid model.
module tb_mac_grid_acc;

  localparam int R = 16;
  localparam int C = 16;
  localparam int DW = 8;
  localparam int WD = 32;
  localparam int A = 17;
  localparam longint MX = 65535;
  localparam longint MN = -65536;

  logic Clk = 1'b0;
  logic reset = 1'b1;
  logic WE = 1'b0;
  logic [3:0] wCol = '0;
  logic [4:0] wAddr = '0;
  logic [7:0] wData = '0;
  logic in_valid = 1'b0;
  logic [R*DW-1:0] data_in = '0;
  logic [R-1:0] rowEn = '0;
  logic [4:0] cAddr = '0;
  logic clr = 1'b0;
  logic rd_req = 1'b0;
  logic [3:0] rd_row = '0;
  logic in_ready_s, in_ready_w, rv_s, rv_w;
  logic [C*A-1:0] do_s, do_w;
  logic [C-1:0] ovf_s, ovf_w;

  int passed = 0;
  int total = 0;

  int wm [C][WD];
  longint ms [R][C];
  longint mw [R][C];
  logic [C-1:0] os, ow;

  typedef struct {
    int row; int col; int d; int ca; bit en; longint exp;
  } vec_t;
  vec_t tv [8];

  always #5 Clk = ~Clk;

  mac_grid_acc #(.ROWS(R), .COLS(C), .DW(DW), .WDEPTH(WD),
                 .ACCW(A), .SAT(1'b1)) dut_s (
    .Clk(Clk), .reset(reset), .WE(WE), .wCol(wCol),
    .wAddr(wAddr), .wData(wData), .in_valid(in_valid),
    .in_ready(in_ready_s), .data_in(data_in), .rowEn(rowEn),
    .cAddr(cAddr), .clr(clr), .rd_req(rd_req), .rd_row(rd_row),
    .rd_valid(rv_s), .dataOut(do_s), .ovf(ovf_s));

  mac_grid_acc #(.ROWS(R), .COLS(C), .DW(DW), .WDEPTH(WD),
                 .ACCW(A), .SAT(1'b0)) dut_w (
    .Clk(Clk), .reset(reset), .WE(WE), .wCol(wCol),
    .wAddr(wAddr), .wData(wData), .in_valid(in_valid),
    .in_ready(in_ready_w), .data_in(data_in), .rowEn(rowEn),
    .cAddr(cAddr), .clr(clr), .rd_req(rd_req), .rd_row(rd_row),
    .rd_valid(rv_w), .dataOut(do_w), .ovf(ovf_w));

  task automatic chk(string nm, longint got, longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic longint gs(int c);
    logic signed [A-1:0] t;
    t = do_s[c*A +: A];
    return t;
  endfunction

  function automatic longint gw(int c);
    logic signed [A-1:0] t;
    t = do_w[c*A +: A];
    return t;
  endfunction

  function automatic longint wrapv(longint v);
    longint t;
    t = v & 64'h1FFFF;
    return (t >= 65536) ? t - 131072 : t;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        ms[r][c] = 0;
        mw[r][c] = 0;
      end
    os = '0;
    ow = '0;
  endtask

  task automatic m_reset();
    m_clear();
    for (int c = 0; c < C; c++)
      for (int a = 0; a < WD; a++) wm[c][a] = 0;
  endtask

  task automatic m_step(logic [R*DW-1:0] dv, logic [R-1:0] en, int ca);
    logic signed [7:0] dd;
    longint p, ts, tw;
    for (int r = 0; r < R; r++) begin
      if (en[r]) begin
        dd = $signed(dv[r*DW +: DW]);
        for (int c = 0; c < C; c++) begin
          p = longint'(dd) * longint'(wm[c][ca]);
          ts = ms[r][c] + p;
          if (ts > MX || ts < MN) begin
            os[c] = 1'b1;
            ts = (ts > MX) ? MX : MN;
          end
          ms[r][c] = ts;
          tw = mw[r][c] + p;
          if (tw > MX || tw < MN) ow[c] = 1'b1;
          mw[r][c] = wrapv(tw);
        end
      end
    end
  endtask

  function automatic logic [R*DW-1:0] mkdv(int row, int d);
    logic [R*DW-1:0] v;
    v = '0;
    v[row*DW +: DW] = d[7:0];
    return v;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cycle(bit v, logic [R*DW-1:0] dv, logic [R-1:0] en,
                       int ca, bit we, int wc, int wa, int w);
    bit acc;
    in_valid = v;
    data_in = dv;
    rowEn = en;
    cAddr = ca[4:0];
    WE = we;
    wCol = wc[3:0];
    wAddr = wa[4:0];
    wData = w[7:0];
    acc = v && in_ready_s;
    tick();
    if (acc) m_step(dv, en, ca);
    if (we) wm[wc][wa] = w;
    in_valid = 1'b0;
    WE = 1'b0;
  endtask

  task automatic wr(int c, int a, int w);
    cycle(1'b0, '0, '0, 0, 1'b1, c, a, w);
  endtask

  task automatic step1(int row, int d, int ca, bit en);
    logic [R-1:0] e;
    e = '0;
    e[row] = en;
    cycle(1'b1, mkdv(row, d), e, ca, 1'b0, 0, 0, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_read(int row, output int lat);
    rd_req = 1'b1;
    rd_row = row[3:0];
    lat = 0;
    while (!rv_s && lat < 20) begin
      tick();
      lat++;
    end
    rd_req = 1'b0;
    if (!rv_s) begin
      total++;
      $display("FAIL read_timeout row %0d: no rd_valid in %0d cycles",
               row, lat);
    end else begin
      chk("rd_valid_wrap", rv_w, 1);
    end
    tick();
    chk("rd_valid_pulse", rv_s, 0);
  endtask

  task automatic chk_row(int row);
    int lat;
    do_read(row, lat);
    for (int c = 0; c < C; c++) begin
      chk($sformatf("sat_r%0d_c%0d", row, c), gs(c), ms[row][c]);
      chk($sformatf("wrap_r%0d_c%0d", row, c), gw(c), mw[row][c]);
    end
    chk("ovf_sat", ovf_s, os);
    chk("ovf_wrap", ovf_w, ow);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit seen;
    logic [R*DW-1:0] dv;
    logic [R-1:0] en;

    tv[0] = '{0, 0, 1, 0, 1'b1, 1};
    tv[1] = '{0, 0, 0, 1, 1'b1, 1};
    tv[2] = '{0, 0, 2, 2, 1'b1, 7};
    tv[3] = '{0, 0, 4, 3, 1'b1, 7};
    tv[4] = '{15, 15, 0, 1, 1'b1, 0};
    tv[5] = '{15, 15, 2, 3, 1'b1, 254};
    tv[6] = '{15, 15, 4, 2, 1'b1, -146};
    tv[7] = '{15, 15, 9, 0, 1'b0, -146};

    m_reset();
    idle(2);
    chk("rst_in_ready", in_ready_s, 1);
    chk("rst_rd_valid", rv_s, 0);
    chk("rst_dataOut", do_s, 0);
    chk("rst_ovf", ovf_s, 0);
    reset = 1'b0;
    idle(1);

    wr(0, 0, 1); wr(0, 1, 2); wr(0, 2, 3); wr(0, 3, 0);
    wr(15, 0, 2); wr(15, 1, 4); wr(15, 2, -100); wr(15, 3, 127);

    foreach (tv[i]) begin
      step1(tv[i].row, tv[i].d, tv[i].ca, tv[i].en);
      idle(3);
      do_read(tv[i].row, lat);
      chk($sformatf("vec%0d_lat", i), lat, 2);
      chk($sformatf("vec%0d_sat", i), gs(tv[i].col), tv[i].exp);
      chk($sformatf("vec%0d_wrap", i), gw(tv[i].col), tv[i].exp);
    end
    chk("no_ovf_yet", ovf_s | ovf_w, 0);

    wr(5, 4, 127);
    for (int i = 0; i < 9; i++) step1(3, 127, 4, 1'b1);
    idle(3);
    chk_row(3);
    chk("sat_clamp", gs(5), 65535);
    chk("wrap_value", gw(5), 14089);
    chk("ovf_sat_c5", ovf_s[5], 1);
    chk("ovf_wrap_c5", ovf_w[5], 1);

    wr(5, 6, 1);
    wr(5, 7, 10);
    step1(3, 5, 6, 1'b1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_clear();
    ms[3][5] = 5;
    mw[3][5] = 5;
    chk_row(3);
    chk("clr_add_sat", gs(5), 5);
    chk("clr_ovf", ovf_s[5], 0);

    cycle(1'b1, mkdv(3, 2), R'(1) << 3, 7, 1'b1, 5, 7, 50);
    chk_row(3);
    chk("rbw_old", gs(5), 25);
    step1(3, 1, 7, 1'b1);
    chk_row(3);
    chk("rbw_new", gs(5), 75);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_clear();
    step1(1, 3, 4, 1'b1);
    step1(1, 5, 4, 1'b1);
    step1(1, 7, 4, 1'b1);
    rd_req = 1'b1;
    rd_row = 4'd1;
    in_valid = 1'b1;
    data_in = mkdv(1, 100);
    rowEn = R'(1) << 1;
    #1;
    chk("b2b_ready_drop", in_ready_s, 0);
    lat = 0;
    seen = 1'b0;
    while (!rv_s && lat < 20) begin
      tick();
      in_valid = 1'b0;
      lat++;
      if (in_ready_s) seen = 1'b1;
    end
    rd_req = 1'b0;
    chk("b2b_lat_range", (lat >= 3 && lat <= 4), 1);
    chk("b2b_ready_low", seen, 0);
    chk("b2b_sum", gs(5), 1905);
    chk("b2b_model", gw(5), mw[1][5]);
    tick();

    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < R; r++) dv[r*DW +: DW] = 8'($urandom);
      en = R'($urandom);
      cycle($urandom_range(0, 3) != 0, dv, en, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 15),
            $urandom_range(0, 7), $urandom_range(0, 255) - 128);
      if (i % 15 == 14) chk_row($urandom_range(0, 15));
    end

    step1(2, 9, 4, 1'b1);
    rd_req = 1'b1;
    rd_row = 4'd2;
    tick();
    reset = 1'b1;
    #1;
    rd_req = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready_s, 1);
    chk("mid_rst_valid", rv_s, 0);
    chk("mid_rst_data", do_s | do_w, 0);
    chk("mid_rst_ovf", ovf_s | ovf_w, 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rv_s || rv_w) seen = 1'b1;
    end
    reset = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rv_s || rv_w) seen = 1'b1;
    end
    chk("mid_rst_no_pulse", seen, 0);
    chk_row(2);
    chk_row(3);
    chk_row(15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
